// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory controller
package dmem_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_HS = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_BS = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;
    typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B} size_e;

    // Unknown encodings fall back to a full-word access.
    function automatic size_e dm_size(input logic [2:0] t);
        case (t)
            DM_HS, DM_HU: return SZ_H;
            DM_BS, DM_BU: return SZ_B;
            default:      return SZ_W;
        endcase
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] a);
        case (dm_size(t))
            SZ_H:    return a[0];
            SZ_B:    return 1'b0;
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between the pipeline and the controller
interface dmem_if;
    logic        req_r;
    logic        req_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_type;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        misalign;

    modport master (output req_r, req_w, addr, wdata, dm_type,
                    input  rdata, ready, busy, misalign);
    modport slave  (input  req_r, req_w, addr, wdata, dm_type,
                    output rdata, ready, busy, misalign);
endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word RAM with per-byte write enables and combinational read
module dmem_ram #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] widx_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] ridx_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - wait-stated data-memory controller: FSM, lane alignment, load extension
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]         type_q, type_d;
    logic               op_w_q, op_w_d;

    logic               req;
    logic               commit;
    logic               acc_w;
    logic [31:0]        acc_addr, acc_wdata;
    logic [2:0]         acc_type;
    logic               ram_we;
    logic [3:0]         ram_be;
    logic [31:0]        ram_wdata, ram_rdata;
    logic [15:0]        ld_half;
    logic [7:0]         ld_byte;
    logic [31:0]        ld_data;
    logic               ld_mis;
    logic               unused_addr;

    assign req = bus.req_r | bus.req_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            op_w_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            op_w_q  <= op_w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        op_w_d  = op_w_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    type_d  = bus.dm_type;
                    op_w_d  = bus.req_w;
                    cnt_d   = CNT_W'(WAIT);
                    state_d = (WAIT == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the store commits straight from the live request.
    assign commit    = ((state_q == ST_IDLE) && req && (WAIT == 0)) ||
                       ((state_q == ST_WAIT) && (cnt_q <= 1));
    assign acc_w     = (state_q == ST_IDLE) ? bus.req_w   : op_w_q;
    assign acc_addr  = (state_q == ST_IDLE) ? bus.addr    : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? bus.wdata   : wdata_q;
    assign acc_type  = (state_q == ST_IDLE) ? bus.dm_type : type_q;

    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = acc_wdata;
        case (dm_size(acc_type))
            SZ_H: begin
                ram_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{acc_wdata[15:0]}};
            end
            SZ_B: begin
                ram_be    = 4'b0001 << acc_addr[1:0];
                ram_wdata = {4{acc_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign ram_we = commit && acc_w && !dm_misaligned(acc_type, acc_addr[1:0]);

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .widx_i  (acc_addr[AW+1:2]),
        .wdata_i (ram_wdata),
        .ridx_i  (addr_q[AW+1:2]),
        .rdata_o (ram_rdata)
    );

    assign ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign ld_byte = ram_rdata[8*addr_q[1:0] +: 8];
    assign ld_mis  = dm_misaligned(type_q, addr_q[1:0]);

    always_comb begin
        case (dm_size(type_q))
            SZ_H:    ld_data = (type_q == DM_HS) ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
            SZ_B:    ld_data = (type_q == DM_BS) ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
            default: ld_data = ram_rdata;
        endcase
    end

    assign bus.ready    = (state_q == ST_DONE);
    assign bus.misalign = (state_q == ST_DONE) && ld_mis;
    assign bus.rdata    = ((state_q == ST_DONE) && !op_w_q && !ld_mis) ? ld_data : 32'h0;
    assign bus.busy     = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && req);

    assign unused_addr = ^{bus.addr[31:AW+2], addr_q[31:AW+2]};
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl (WAIT=2, DEPTH=256)
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    dmem_if bus();

    dmem_ctrl #(.DEPTH(256), .WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", bus.rdata, mon_e[31:0]);
                chk("misalign", {31'b0, bus.misalign}, {31'b0, mon_e[32]});
            end
        end
    end

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] t,
                          input logic [31:0] er, input logic em);
        int  k;
        bit  got;
        exp_q.push_back({em, er});
        @(negedge clk);
        bus.req_w = w; bus.req_r = r; bus.addr = a; bus.wdata = wd; bus.dm_type = t;
        #1 chk("busy_req", {31'b0, bus.busy}, 32'd1);
        k = 0;
        got = 0;
        while (!got && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            #1;
            if (bus.ready) begin
                got = 1;
            end else begin
                chk("busy_wait", {31'b0, bus.busy}, 32'd1);
                chk("rdata_idle", bus.rdata, 32'h0);
            end
        end
        if (!got) chk("timeout", 32'd0, 32'd1);
        chk("latency", k, 32'd3);
        chk("busy_done", {31'b0, bus.busy}, 32'd0);
        bus.req_w = 1'b0;
        bus.req_r = 1'b0;
    endtask

    initial begin
        bus.req_r = 1'b0; bus.req_w = 1'b0; bus.addr = '0; bus.wdata = '0; bus.dm_type = DM_W;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, bus.ready}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mis", {31'b0, bus.misalign}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        reset = 1'b1;

        access(1, 0, 32'h10, 32'hDEADBEEF, DM_W,  32'h0,        0);
        access(0, 1, 32'h10, 32'h0,        DM_W,  32'hDEADBEEF, 0);
        access(1, 0, 32'h13, 32'h00000080, DM_BS, 32'h0,        0);
        access(0, 1, 32'h13, 32'h0,        DM_BS, 32'hFFFFFF80, 0);
        access(0, 1, 32'h13, 32'h0,        DM_BU, 32'h00000080, 0);
        access(0, 1, 32'h10, 32'h0,        DM_W,  32'h80ADBEEF, 0);
        access(1, 0, 32'h11, 32'h00001234, DM_HU, 32'h0,        1);
        access(0, 1, 32'h10, 32'h0,        DM_W,  32'h80ADBEEF, 0);
        access(0, 1, 32'h12, 32'h0,        DM_HS, 32'hFFFF80AD, 0);
        access(0, 1, 32'h10, 32'h0,        DM_HU, 32'h0000BEEF, 0);
        access(0, 1, 32'h11, 32'h0,        DM_BU, 32'h000000BE, 0);
        access(0, 1, 32'h12, 32'h0,        DM_W,  32'h0,        1);
        access(0, 1, 32'h10, 32'h0,        3'b111, 32'h80ADBEEF, 0);

        access(1, 0, 32'h20, 32'h0BADF00D, DM_W,  32'h0,        0);
        @(negedge clk);
        bus.req_w = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h11111111; bus.dm_type = DM_W;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.req_w = 1'b0;
        #1;
        chk("wrst_ready", {31'b0, bus.ready}, 32'd0);
        chk("wrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("wrst_mis", {31'b0, bus.misalign}, 32'd0);
        chk("wrst_rdata", bus.rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        access(0, 1, 32'h20, 32'h0,        DM_W,  32'h0BADF00D, 0);

        access(1, 1, 32'h24, 32'hCAFE0001, DM_W,  32'h0,        0);
        access(0, 1, 32'h24, 32'h0,        DM_W,  32'hCAFE0001, 0);
        access(1, 0, 32'h410, 32'h5A5A5A5A, DM_W, 32'h0,        0);
        access(0, 1, 32'h010, 32'h0,       DM_W,  32'h5A5A5A5A, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
